// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters.
// State | meaning: IDLE arbitrate | LAUNCH issue start | WAIT_ACK master accepts | WAIT_DONE master runs | GAP bus idle
module i2c_req_arbiter #(
    parameter int N_REQ        = 3,
    parameter int GAP_CYCLES   = 4,
    parameter int ACK_TIMEOUT  = 16,
    parameter int DONE_TIMEOUT = 600000
) (
    input  logic                 i2c_clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [35*N_REQ-1:0]  req_cmd,
    input  logic                 i2c_ready,
    output logic                 i2c_start,
    output logic [6:0]           slave_addr,
    output logic                 cmd_byte,
    output logic [15:0]          i2c_cmd,
    output logic [5:0]           wait_time,
    output logic [2:0]           data_byte,
    output logic [1:0]           num,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 busy
);

    localparam int          PW        = $clog2(N_REQ);
    localparam logic [19:0] ACK_LAST  = 20'(ACK_TIMEOUT - 1);
    localparam logic [19:0] DONE_LAST = 20'(DONE_TIMEOUT - 1);
    localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t            state, next_state;
    logic [19:0]       cnt, next_cnt;
    logic [PW-1:0]     ptr, next_ptr, sel, idx;
    logic              found;
    logic [34:0]       desc, next_desc;
    logic [N_REQ-1:0]  next_grant, next_done, next_err;
    logic              next_start;

    // First pending request after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = ptr;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_ptr   = ptr;
        next_grant = grant;
        next_desc  = desc;
        next_done  = '0;
        next_err   = '0;
        next_start = 1'b0;
        case (state)
            IDLE: begin
                if (found && i2c_ready) begin
                    next_grant      = '0;
                    next_grant[sel] = 1'b1;
                    next_desc       = req_cmd[35*int'(sel) +: 35];
                    next_ptr        = sel;
                    next_state      = LAUNCH;
                end
            end
            // start is registered, so the master sees it the cycle after grant
            LAUNCH: begin
                next_start = 1'b1;
                next_cnt   = '0;
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!i2c_ready) begin
                    next_cnt   = '0;
                    next_state = WAIT_DONE;
                end else if (cnt >= ACK_LAST) begin
                    next_err   = grant;
                    next_grant = '0;
                    next_desc  = '0;
                    next_cnt   = '0;
                    next_state = GAP;
                end else begin
                    next_cnt = cnt + 20'd1;
                end
            end
            WAIT_DONE: begin
                if (i2c_ready) begin
                    next_done  = grant;
                    next_grant = '0;
                    next_desc  = '0;
                    next_cnt   = '0;
                    next_state = GAP;
                end else if (cnt >= DONE_LAST) begin
                    next_err   = grant;
                    next_grant = '0;
                    next_desc  = '0;
                    next_cnt   = '0;
                    next_state = GAP;
                end else begin
                    next_cnt = cnt + 20'd1;
                end
            end
            GAP: begin
                if (cnt >= GAP_LAST) begin
                    next_cnt   = '0;
                    next_state = IDLE;
                end else begin
                    next_cnt = cnt + 20'd1;
                end
            end
            default: begin
                next_cnt   = '0;
                next_grant = '0;
                next_desc  = '0;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i2c_clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= PW'(N_REQ - 1);
            grant     <= '0;
            desc      <= '0;
            done      <= '0;
            err       <= '0;
            i2c_start <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            ptr       <= next_ptr;
            grant     <= next_grant;
            desc      <= next_desc;
            done      <= next_done;
            err       <= next_err;
            i2c_start <= next_start;
        end
    end

    assign slave_addr = desc[34:28];
    assign cmd_byte   = desc[27];
    assign i2c_cmd    = desc[26:11];
    assign wait_time  = desc[10:5];
    assign data_byte  = desc[4:2];
    assign num        = desc[1:0];
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter with a behavioural I2C master driving i2c_ready.
module tb_i2c_req_arbiter;

    localparam int TB_GAP  = 4;
    localparam int TB_ACK  = 16;
    localparam int TB_DONE = 50;

    localparam logic [34:0] D_A   = {7'h3C, 1'b0, 16'h00AF, 6'd2,  3'd1, 2'd1};
    localparam logic [34:0] D_SHT = {7'h44, 1'b1, 16'h2400, 6'd16, 3'd6, 2'd0};
    localparam logic [34:0] D_B   = {7'h68, 1'b1, 16'hD0F1, 6'd63, 3'd7, 2'd3};

    typedef struct packed {
        logic [2:0]  kind;   // {start, done, err}
        logic [2:0]  gnt;
        logic [2:0]  pulse;
        logic [34:0] desc;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req = '0;
    logic [104:0] req_cmd = {D_B, D_SHT, D_A};
    logic         i2c_ready = 1'b0;
    logic         i2c_start, cmd_byte, busy;
    logic [6:0]   slave_addr;
    logic [15:0]  i2c_cmd;
    logic [5:0]   wait_time;
    logic [2:0]   data_byte;
    logic [1:0]   num;
    logic [2:0]   grant, done, err;

    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t exp_q[$];
    int  m_ack_delay = 3;
    int  m_busy_len  = 20;
    bit  m_block     = 1'b0;
    int  n;

    always #5 clk = ~clk;

    i2c_req_arbiter #(
        .N_REQ(3), .GAP_CYCLES(TB_GAP), .ACK_TIMEOUT(TB_ACK), .DONE_TIMEOUT(TB_DONE)
    ) dut (
        .i2c_clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .i2c_ready(i2c_ready),
        .i2c_start(i2c_start), .slave_addr(slave_addr), .cmd_byte(cmd_byte),
        .i2c_cmd(i2c_cmd), .wait_time(wait_time), .data_byte(data_byte), .num(num),
        .grant(grant), .done(done), .err(err), .busy(busy)
    );

    function automatic ev_t mk(logic [2:0] k, logic [2:0] g, logic [2:0] p, logic [34:0] d);
        ev_t e;
        e.kind  = k;
        e.gnt   = g;
        e.pulse = p;
        e.desc  = d;
        return e;
    endfunction

    task automatic push_start(logic [2:0] g, logic [34:0] d);
        exp_q.push_back(mk(3'b100, g, 3'b000, d));
    endtask

    task automatic push_txn(logic [2:0] g, logic [34:0] d, bit ok);
        push_start(g, d);
        exp_q.push_back(mk(ok ? 3'b010 : 3'b001, 3'b000, g, 35'd0));
    endtask

    task automatic check(string name, logic [63:0] got, logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        ev_t got, e;
        int  cyc = 0;
        int  last_end = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                last_end = -1;
            end else if (i2c_start || (|done) || (|err)) begin
                got = mk({i2c_start, |done, |err}, grant, done | err,
                         {slave_addr, cmd_byte, i2c_cmd, wait_time, data_byte, num});
                if (i2c_start && last_end >= 0) begin
                    n_tests++;
                    if (cyc - last_end < TB_GAP + 2) begin
                        n_fail++;
                        $display("FAIL start_spacing got=%0d exp>=%0d", cyc - last_end, TB_GAP + 2);
                    end
                end
                if ((|done) || (|err)) last_end = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard got=%h exp=%h", got, e);
                    end
                end
            end
        end
    endtask

    // Master: ready drops m_ack_delay cycles after start and stays low m_busy_len cycles (<0 = never).
    task automatic master_loop();
        int ph = 0;
        int c  = 0;
        forever begin
            @(negedge clk);
            if (m_block) begin
                i2c_ready = 1'b0;
                ph = 0;
            end else begin
                case (ph)
                    0: begin
                        i2c_ready = 1'b1;
                        if (i2c_start && m_ack_delay >= 0) begin
                            c  = 0;
                            ph = 1;
                        end
                    end
                    1: begin
                        c++;
                        if (c >= m_ack_delay) begin
                            i2c_ready = 1'b0;
                            c  = 0;
                            ph = (m_busy_len < 0) ? 3 : 2;
                        end
                    end
                    2: begin
                        c++;
                        if (c >= m_busy_len) begin
                            i2c_ready = 1'b1;
                            ph = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic wait_start(int max, output int cnt);
        cnt = 0;
        while (!i2c_start && cnt < max) begin
            tick();
            cnt++;
        end
        if (!i2c_start) check("wait_start_timeout", 64'(i2c_start), 64'd1);
    endtask

    task automatic wait_end(int max, output int cnt);
        cnt = 0;
        while (!((|done) || (|err)) && cnt < max) begin
            tick();
            cnt++;
        end
        if (!((|done) || (|err))) check("wait_end_timeout", 64'(done | err), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_block = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        m_block = 1'b0;
        tick();
    endtask

    initial begin
        fork
            monitor_loop();
            master_loop();
            begin
                repeat (20000) @(negedge clk);
                $display("FAIL watchdog got=timeout exp=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // reset state
        m_block = 1'b1;
        tick();
        tick();
        check("reset_state", 64'({i2c_start, busy, grant, done, err, slave_addr, cmd_byte,
                                  i2c_cmd, wait_time, data_byte, num}), 64'd0);
        rst = 1'b0;
        m_block = 1'b0;
        tick();

        // single request, descriptor changes and req drop after grant are ignored
        push_txn(3'b010, D_SHT, 1'b1);
        req = 3'b010;
        tick();
        check("grant_latency", 64'({grant, i2c_start, busy}), 64'({3'b010, 1'b0, 1'b1}));
        req_cmd[69:35] = ~D_SHT;
        tick();
        check("start_latency", 64'({grant, i2c_start}), 64'({3'b010, 1'b1}));
        req = 3'b000;
        wait_end(200, n);
        for (int i = 0; i < TB_GAP - 1; i++) begin
            tick();
            check("busy_in_gap", 64'(busy), 64'd1);
        end
        tick();
        check("busy_after_gap", 64'(busy), 64'd0);
        req_cmd = {D_B, D_SHT, D_A};

        // contention: rotation 0,1,2,0
        do_reset();
        push_txn(3'b001, D_A, 1'b1);
        push_txn(3'b010, D_SHT, 1'b1);
        push_txn(3'b100, D_B, 1'b1);
        push_txn(3'b001, D_A, 1'b1);
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_start(100, n);
            wait_end(100, n);
        end
        req = 3'b000;

        // master busy: no grant until ready rises, then grant next cycle
        m_block = 1'b1;
        tick();
        tick();
        push_txn(3'b001, D_A, 1'b1);
        req = 3'b001;
        repeat (5) tick();
        check("hold_while_not_ready", 64'({grant, busy}), 64'd0);
        m_block = 1'b0;
        n = 0;
        while (!i2c_ready && n < 10) begin
            tick();
            n++;
        end
        check("ready_rise_no_grant_yet", 64'({i2c_ready, grant}), 64'({1'b1, 3'b000}));
        tick();
        check("grant_after_ready", 64'(grant), 64'(3'b001));
        wait_end(200, n);
        req = 3'b000;

        // ack timeout on req0, then req1 served normally
        do_reset();
        m_ack_delay = -1;
        push_txn(3'b001, D_A, 1'b0);
        push_txn(3'b010, D_SHT, 1'b1);
        req = 3'b011;
        wait_start(100, n);
        wait_end(100, n);
        check("ack_timeout_cycles", 64'(n), 64'(TB_ACK));
        check("ack_timeout_grant_clr", 64'(grant), 64'd0);
        m_ack_delay = 3;
        req = 3'b010;
        wait_start(100, n);
        wait_end(200, n);
        req = 3'b000;

        // done timeout: ready never returns
        m_ack_delay = 1;
        m_busy_len = -1;
        push_txn(3'b100, D_B, 1'b0);
        req = 3'b100;
        wait_start(100, n);
        wait_end(200, n);
        check("done_timeout_cycles", 64'(n), 64'(2 + TB_DONE));
        req = 3'b000;
        m_block = 1'b1;
        tick();
        m_block = 1'b0;
        tick();

        // ready returns on the timeout cycle: done wins
        m_busy_len = TB_DONE;
        push_txn(3'b100, D_B, 1'b1);
        req = 3'b100;
        wait_start(100, n);
        wait_end(200, n);
        check("done_at_timeout_cycles", 64'(n), 64'(2 + TB_DONE));
        req = 3'b000;

        // reset in WAIT_DONE: silent abort, pointer back to req0
        m_ack_delay = 3;
        m_busy_len = 20;
        push_start(3'b010, D_SHT);
        req = 3'b010;
        wait_start(100, n);
        repeat (8) tick();
        check("in_wait_done", 64'({busy, grant}), 64'({1'b1, 3'b010}));
        rst = 1'b1;
        m_block = 1'b1;
        req = 3'b000;
        tick();
        check("reset_mid_clear", 64'({i2c_start, busy, grant, done, err, slave_addr, cmd_byte,
                                      i2c_cmd, wait_time, data_byte, num}), 64'd0);
        tick();
        rst = 1'b0;
        m_block = 1'b0;
        tick();
        push_txn(3'b001, D_A, 1'b1);
        req = 3'b111;
        wait_start(100, n);
        wait_end(200, n);
        req = 3'b000;
        repeat (12) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
